// File: rtl/fifo_burst_reader.sv
// Burst read controller for the synchronous FIFO: drains burst_len words into a
// valid/ready stream through a 3-entry skid buffer that hides the FIFO read latency.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  // Stream handshake: a word moves when out_valid && out_ready && enable are all
  // high at the rising edge; out_valid/out_data/out_last hold until that happens.

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  issue_rem_q, issue_rem_d;
  logic [LEN_WIDTH-1:0]  out_rem_q, out_rem_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] buf_q [0:2];
  logic [DATA_WIDTH-1:0] buf_d [0:2];

  logic accept;
  logic xfer;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue only when a slot is guaranteed for the word, counting the one in flight.
  assign fifo_rd_en = enable && (state_q == RUN) && (issue_rem_q != '0) && !fifo_empty &&
                      (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign accept     = fifo_rd_en && !fifo_empty;
  assign out_valid  = (count_q != 2'd0);
  assign xfer       = out_valid && out_ready && enable;
  assign out_data   = buf_q[rd_ptr_q];
  assign out_last   = out_valid && (out_rem_q == LEN_WIDTH'(1));
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    issue_rem_d = issue_rem_q;
    out_rem_d   = out_rem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    buf_d       = buf_q;
    inflight_d  = accept;

    // The FIFO returns data one cycle after acceptance even if enable dropped.
    if (inflight_q) begin
      buf_d[wr_ptr_q] = fifo_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (xfer) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      if (out_rem_q != '0) out_rem_d = out_rem_q - LEN_WIDTH'(1);
    end
    case ({inflight_q, xfer})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (accept) issue_rem_d = issue_rem_q - LEN_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (start && enable) begin
          issue_rem_d = burst_len;
          out_rem_d   = burst_len;
          state_d     = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN:     if (accept && (issue_rem_q == LEN_WIDTH'(1))) state_d = FLUSH;
      FLUSH:   if (xfer && (out_rem_q == LEN_WIDTH'(1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 2'd0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      issue_rem_q <= issue_rem_d;
      out_rem_q   <= out_rem_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO with registered data_out,
// directed bursts, and a stream monitor checking against an expected queue.
module tb_fifo_burst_reader;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       start;
  logic [15:0] burst_len;
  logic       busy;
  logic       done;
  logic       fifo_rd_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  logic [8:0] exp_q[$];

  // FIFO model
  logic [7:0] mem [0:63];
  int wr_idx = 0;
  int rd_idx = 0;
  assign fifo_empty = (wr_idx == rd_idx);

  fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial fifo_data = 8'h00;
  always @(posedge clk) begin
    if (fifo_rd_en && (wr_idx != rd_idx)) begin
      fifo_data <= mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en && !fifo_empty) rd_cnt++;
      if (done) done_cnt++;
      if (fifo_rd_en && fifo_empty) begin
        checks++;
        errors++;
        $display("FAIL rd_while_empty: fifo_rd_en=1 fifo_empty=1 required fifo_rd_en=0");
      end
      if (out_valid && out_ready && enable) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got data=%02h last=%0b, required no word", out_data, out_last);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL stream_word: got data=%02h last=%0b, required data=%02h last=%0b",
                     out_data, out_last, e[7:0], e[8]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_fifo(input logic [7:0] w);
    mem[wr_idx] = w;
    wr_idx = wr_idx + 1;
  endtask

  task automatic expect_burst(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_fifo(base + 8'(i));
      exp_q.push_back({(i == n - 1), base + 8'(i)});
    end
  endtask

  task automatic do_start(input logic [15:0] len);
    start = 1'b1;
    burst_len = len;
    tick();
    start = 1'b0;
    burst_len = 16'd0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    tick();
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int r0, d0;
    logic [7:0] rd_tab, vl_tab, ls_tab, dn_tab, by_tab;
    rst = 1'b1; enable = 1'b1; start = 1'b0; burst_len = 16'd0; out_ready = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // burst of 4 at full rate, cycle-accurate
    push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33); push_fifo(8'h44);
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h33}); exp_q.push_back({1'b1, 8'h44});
    rd_tab = 8'b0000_1111; vl_tab = 8'b0011_1100; ls_tab = 8'b0010_0000;
    dn_tab = 8'b0100_0000; by_tab = 8'b0111_1111;
    d0 = done_cnt;
    do_start(16'd4);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("b4_rd_en_%0d", j), {31'd0, fifo_rd_en}, {31'd0, rd_tab[j]});
      check($sformatf("b4_valid_%0d", j), {31'd0, out_valid}, {31'd0, vl_tab[j]});
      check($sformatf("b4_last_%0d", j), {31'd0, out_last}, {31'd0, ls_tab[j]});
      check($sformatf("b4_done_%0d", j), {31'd0, done}, {31'd0, dn_tab[j]});
      check($sformatf("b4_busy_%0d", j), {31'd0, busy}, {31'd0, by_tab[j]});
      if (j == 2) check("b4_first_data", {24'd0, out_data}, 32'h11);
      if (j < 7) tick();
    end
    check("b4_done_count", done_cnt - d0, 32'd1);

    // zero-length burst
    r0 = rd_cnt;
    do_start(16'd0);
    check("b0_done", {31'd0, done}, 32'd1);
    check("b0_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("b0_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("b0_done_off", {31'd0, done}, 32'd0);
    check("b0_busy", {31'd0, busy}, 32'd0);
    check("b0_reads", rd_cnt - r0, 32'd0);

    // back-pressure: only 3 reads until the consumer is ready
    expect_burst(8'hA0, 6);
    out_ready = 1'b0;
    r0 = rd_cnt;
    do_start(16'd6);
    for (int j = 0; j < 10; j++) begin
      if (j >= 2) begin
        check($sformatf("bp_valid_%0d", j), {31'd0, out_valid}, 32'd1);
        check($sformatf("bp_hold_%0d", j), {24'd0, out_data}, 32'hA0);
      end
      if (j < 9) tick();
    end
    check("bp_reads_stalled", rd_cnt - r0, 32'd3);
    check("bp_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
    out_ready = 1'b1;
    wait_done("bp");
    check("bp_reads_total", rd_cnt - r0, 32'd6);

    // FIFO runs dry mid-burst
    push_fifo(8'hB0); push_fifo(8'hB1);
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 8'hB0 + 8'(i)});
    r0 = rd_cnt;
    do_start(16'd5);
    for (int j = 0; j < 8; j++) tick();
    check("dry_reads_paused", rd_cnt - r0, 32'd2);
    check("dry_busy", {31'd0, busy}, 32'd1);
    push_fifo(8'hB2); push_fifo(8'hB3); push_fifo(8'hB4);
    wait_done("dry");
    check("dry_reads_total", rd_cnt - r0, 32'd5);

    // enable dropped with a read in flight
    expect_burst(8'hC0, 6);
    r0 = rd_cnt;
    do_start(16'd6);
    tick();
    enable = 1'b0;
    #1;
    check("en_rd_en_off", {31'd0, fifo_rd_en}, 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("en_rd_en_%0d", j), {31'd0, fifo_rd_en}, 32'd0);
      check($sformatf("en_valid_%0d", j), {31'd0, out_valid}, 32'd1);
      check($sformatf("en_data_%0d", j), {24'd0, out_data}, 32'hC0);
    end
    check("en_reads_frozen", rd_cnt - r0, 32'd1);
    enable = 1'b1;
    wait_done("en");
    check("en_reads_total", rd_cnt - r0, 32'd6);

    // reset mid-burst with words buffered
    for (int i = 0; i < 6; i++) push_fifo(8'hD0 + 8'(i));
    out_ready = 1'b0;
    r0 = rd_cnt;
    do_start(16'd6);
    tick(); tick(); tick();
    check("mr_valid_before", {31'd0, out_valid}, 32'd1);
    check("mr_reads_before", rd_cnt - r0, 32'd3);
    rst = 1'b1;
    #1;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_last", {31'd0, out_last}, 32'd0);
    check("mr_data", {24'd0, out_data}, 32'd0);
    check("mr_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_q.push_back({1'b1, 8'hD3});
    r0 = rd_cnt;
    do_start(16'd1);
    wait_done("mr");
    check("mr_reads_after", rd_cnt - r0, 32'd1);

    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
